xort_pulse_monitor: RTL and testbench

- Synchronous receiver for toggle-encoded SFQ pulse streams around a clocked XOR (XORT) cell. Sits in the verification/readout path.
- Pulse-line levels (each level change = one SFQ pulse) are sampled on the system clock. Edges are decoded into pulse events.
- The monitor tracks the XORT protocol state, predicts expected q pulses, and counts/flags protocol and latency errors.
- It is the reader for the pulse streams that the XORT cell model produces and consumes.

---
 rtl/xort_pulse_monitor.sv | 116 +++++++++++
 tb/tb_xort_pulse_monitor.sv | 101 ++++++++++
 2 files changed

// File: rtl/xort_pulse_monitor.sv
// xort_pulse_monitor: XORT pulse-stream protocol/latency monitor; define XORT_SETUP_CHECK_EN to add sclk setup checking (err_setup)
module xort_pulse_monitor #(
  parameter int MAX_LAT    = 4,
  parameter int PEND_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int SETUP_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_lvl,
  input  logic             b_lvl,
  input  logic             sclk_lvl,
  input  logic             q_lvl,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_dup,
  output logic             err_miss,
  output logic             err_spur,
  output logic             err_ovf,
`ifdef XORT_SETUP_CHECK_EN
  output logic             err_setup,
`endif
  output logic             busy
);
  localparam int AW = $clog2(MAX_LAT + 1);
  localparam int CW = $clog2(PEND_DEPTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, GOT_A = 2'd1, GOT_B = 2'd2} state_t;
  logic a_p, b_p, s_p, q_p;
  logic a_pu, b_pu, s_pu, q_pu;
  state_t state, state_nx, mid_a, mid_b;
  logic dup, push, pop_q, spur, miss, pop, ovf, ins;
  logic [AW-1:0] age [PEND_DEPTH];
  logic [AW-1:0] age_nx [PEND_DEPTH];
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] nerr;
  logic [CNT_W:0] err_sum;
  // Tracking the previous level unconditionally also makes reset load the live levels.
  always_ff @(posedge clk) {a_p, b_p, s_p, q_p} <= {a_lvl, b_lvl, sclk_lvl, q_lvl};
  assign a_pu = en & (a_lvl ^ a_p);
  assign b_pu = en & (b_lvl ^ b_p);
  assign s_pu = en & (sclk_lvl ^ s_p);
  assign q_pu = en & (q_lvl ^ q_p);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // Data lines resolve a before b; sclk closes the window last.
  always_comb begin
    mid_a    = !a_pu ? state : state == IDLE ? GOT_A : state == GOT_B ? IDLE : state;
    mid_b    = !b_pu ? mid_a : mid_a == IDLE ? GOT_B : mid_a == GOT_A ? IDLE : mid_a;
    state_nx = s_pu ? IDLE : mid_b;
  end
  always_comb begin
    dup  = (a_pu && state == GOT_A) || (b_pu && mid_a == GOT_B);
    push = s_pu && mid_b != IDLE;
  end
  assign pop_q = q_pu && cnt != '0;
  assign spur  = q_pu && cnt == '0;
  assign miss  = !q_pu && cnt != '0 && age[0] == AW'(MAX_LAT);
  assign pop   = pop_q | miss;
  assign ovf   = push && !pop && cnt == CW'(PEND_DEPTH);
  assign ins   = push && !ovf;
  assign cnt_nx = cnt - CW'(pop) + CW'(ins);
  assign busy  = cnt != '0;
  // Entry 0 is always the oldest; a pop shifts the queue down.
  always_comb begin
    for (int i = 0; i < PEND_DEPTH; i++) begin
      age_nx[i] = (pop && i < PEND_DEPTH - 1) ? age[(i + 1) % PEND_DEPTH] + AW'(1) : age[i] + AW'(1);
      if (ins && CW'(i) == cnt - CW'(pop)) age_nx[i] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) age[i] <= '0;
    end else if (en) begin
      cnt <= cnt_nx;
      age <= age_nx;
    end
  end
`ifdef XORT_SETUP_CHECK_EN
  localparam int SW = $clog2(SETUP_CYC + 2);
  logic [SW-1:0] since, dist;
  logic setup;
  assign dist  = (a_pu | b_pu) ? '0 : since;
  assign setup = s_pu && dist < SW'(SETUP_CYC);
  always_ff @(posedge clk) begin
    if (rst) begin
      since     <= SW'(SETUP_CYC);
      err_setup <= 1'b0;
    end else begin
      err_setup <= setup;
      if (en) since <= (a_pu | b_pu) ? SW'(1) : since < SW'(SETUP_CYC) ? since + SW'(1) : since;
    end
  end
  assign nerr = 3'(dup) + 3'(miss) + 3'(spur) + 3'(ovf) + 3'(setup);
`else
  assign nerr = 3'(dup) + 3'(miss) + 3'(spur) + 3'(ovf);
`endif
  assign err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(nerr);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt    <= '0;
      err_cnt  <= '0;
      err_dup  <= 1'b0;
      err_miss <= 1'b0;
      err_spur <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      q_cnt    <= q_cnt + CNT_W'(pop_q);
      err_cnt  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      err_dup  <= dup;
      err_miss <= miss;
      err_spur <= spur;
      err_ovf  <= ovf;
    end
  end
endmodule

// File: tb/tb_xort_pulse_monitor.sv
// tb_xort_pulse_monitor: scoreboard bench for xort_pulse_monitor, narrow counters to reach saturation
module tb_xort_pulse_monitor;
  localparam int CW = 3;
  localparam int ML = 4;
  localparam int PD = 4;
  logic clk = 0, rst = 1, en = 1, a_lvl = 0, b_lvl = 0, sclk_lvl = 0, q_lvl = 0;
  logic [CW-1:0] q_cnt, err_cnt;
  logic err_dup, err_miss, err_spur, err_ovf, busy;
`ifdef XORT_SETUP_CHECK_EN
  logic err_setup;
`endif
  always #5 clk = ~clk;
  xort_pulse_monitor #(.MAX_LAT(ML), .PEND_DEPTH(PD), .CNT_W(CW), .SETUP_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .a_lvl(a_lvl), .b_lvl(b_lvl), .sclk_lvl(sclk_lvl),
    .q_lvl(q_lvl), .q_cnt(q_cnt), .err_cnt(err_cnt), .err_dup(err_dup),
    .err_miss(err_miss), .err_spur(err_spur), .err_ovf(err_ovf),
`ifdef XORT_SETUP_CHECK_EN
    .err_setup(err_setup),
`endif
    .busy(busy));
  typedef struct packed {logic [3:0] fl; logic [CW-1:0] qc; logic [CW-1:0] ec; logic bz;} exp_t;
  exp_t sb[$];
  int ages[$];
  int st = 0, m_qc = 0, m_ec = 0, n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic cyc(input bit pa, input bit pb, input bit ps, input bit pq, input bit e = 1, input bit r = 0);
    bit dup = 0, miss = 0, spur = 0, ovf = 0;
    int n;
    exp_t x;
    a_lvl = a_lvl ^ pa; b_lvl = b_lvl ^ pb; sclk_lvl = sclk_lvl ^ ps; q_lvl = q_lvl ^ pq;
    en = e; rst = r;
    if (r) begin
      st = 0; ages.delete(); m_qc = 0; m_ec = 0;
    end else if (e) begin
      if (pa) begin if (st == 0) st = 1; else if (st == 1) dup = 1; else st = 0; end
      if (pb) begin if (st == 0) st = 2; else if (st == 2) dup = 1; else st = 0; end
      if (pq) begin
        if (ages.size() == 0) spur = 1;
        else begin void'(ages.pop_front()); m_qc = (m_qc + 1) % (1 << CW); end
      end else if (ages.size() > 0 && ages[0] == ML) begin
        miss = 1; void'(ages.pop_front());
      end
      foreach (ages[i]) ages[i]++;
      if (ps && st != 0) begin
        st = 0;
        if (ages.size() == PD) ovf = 1; else ages.push_back(0);
      end
      n = int'(dup) + int'(miss) + int'(spur) + int'(ovf);
      m_ec = (m_ec + n > (1 << CW) - 1) ? (1 << CW) - 1 : m_ec + n;
    end
    x.fl = {dup, miss, spur, ovf}; x.qc = m_qc[CW-1:0]; x.ec = m_ec[CW-1:0]; x.bz = ages.size() > 0;
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    check("err_dup", int'(err_dup), int'(x.fl[3]));
    check("err_miss", int'(err_miss), int'(x.fl[2]));
    check("err_spur", int'(err_spur), int'(x.fl[1]));
    check("err_ovf", int'(err_ovf), int'(x.fl[0]));
    check("q_cnt", int'(q_cnt), int'(x.qc));
    check("err_cnt", int'(err_cnt), int'(x.ec));
    check("busy", int'(busy), int'(x.bz));
  endtask
  initial begin
    #1;
    cyc(0, 0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 1, 1);
    check("reset_busy", int'(busy), 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
    check("t1_busy_push", int'(busy), 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    check("t1_q_cnt", int'(q_cnt), 1);
    check("t1_err_cnt", int'(err_cnt), 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    check("t2_spur", int'(err_spur), 1);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check("t3_err_cnt", int'(err_cnt), 2);
    cyc(1, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    check("lat_edge_q_cnt", int'(q_cnt), 2);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
    check("t4_ovf", int'(err_ovf), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    check("t4_q_cnt", int'(q_cnt), 6);
    check("t4_busy", int'(busy), 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
    check("t5_busy", int'(busy), 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    check("t5_err_cnt", int'(err_cnt), 0);
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    check("en_spur", int'(err_cnt), 1);
    cyc(1, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    check("err_sat", int'(err_cnt), 7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
